uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 16, giving the clock_enable ticks per serial bit; legal range 4..256.
REQ-002 SHALL have parameter STOP_BITS, default 1, giving the number of stop bits; legal values 1 or 2.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CLKIN, input, 1 bit: the single clock; all flops are rising-edge.
REQ-005 SHALL have port RESETN, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port clock_enable, input, 1 bit: baud oversample tick; serial timing advances only on cycles where it is high.
REQ-007 SHALL have port data, input, 8 bits: byte to send, LSB first.
REQ-008 SHALL have port valid, input, 1 bit: data is offered.
REQ-009 SHALL have port ready, output, 1 bit: registered; high only in IDLE.
REQ-010 SHALL have port tx, output, 1 bit: registered serial line; idle level is 1.

Function
REQ-011 SHALL use states IDLE, START, DATA and STOP.
REQ-012 SHALL accept a byte on any CLKIN edge with valid=1 and ready=1, independent of clock_enable.
REQ-013 SHALL capture data into an internal shift register at acceptance, so later changes on data have no effect.
REQ-014 SHALL, on the accepting edge, go to START, drive tx=0, drive ready=0, and clear the tick counter and bit index.
REQ-015 SHALL hold tx=0 in START for exactly TICKS_PER_BIT enabled ticks, then go to DATA with tx=data[0].
REQ-016 SHALL hold each data bit in DATA for TICKS_PER_BIT enabled ticks, bits 0..7 in order; the bit index is 3 bits and the DATA-to-STOP exit is on index 7 (no wrap).
REQ-017 SHALL drive tx=1 in STOP for TICKS_PER_BIT*STOP_BITS enabled ticks.
REQ-018 SHALL, on the last STOP tick, enter IDLE with ready=1 on the same edge.
REQ-019 SHALL size the tick counter to cover TICKS_PER_BIT*STOP_BITS-1; it resets to 0 at every bit boundary and never wraps mid-bit.
REQ-020 SHALL make a frame last exactly (9+STOP_BITS)*TICKS_PER_BIT enabled ticks from the accepting edge to ready=1.
REQ-021 SHALL ignore valid while ready=0: no queuing and no corruption of the frame in flight.
REQ-022 SHALL allow back-to-back operation: valid held high accepts the next byte on the first edge with ready=1, with no extra idle ticks.
REQ-023 SHALL, when clock_enable is low, freeze state, counters and tx.
REQ-024 SHALL treat clock_enable=0 for arbitrarily long as legal.
REQ-025 SHALL drive tx=1 whenever in IDLE.

Reset
REQ-026 SHALL, while RESETN=0, force state=IDLE, tx=1, ready=0, and clear the counters and shift register, asynchronously.
REQ-027 SHALL drive ready=1 on the first CLKIN edge after RESETN deasserts.
REQ-028 SHALL, on reset mid-frame, abort the frame: tx returns to 1 immediately, no partial bits resume, and the dropped byte is not retransmitted.

Structure
REQ-029 SHALL take the state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default oversample constant UART_TICKS_PER_BIT=16 from shared package uart_pkg, which the receiver also uses.
REQ-030 SHALL be a single module with no sub-module; the tick counter is inline.

Verification
REQ-031 SHALL cover this scenario: clock_enable=1 constant, send 0xA5 -> tx is 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 for 16 cycles each, then 1 for 16; ready returns at cycle 160.
REQ-032 SHALL cover this scenario: tx looped to uart_receiver rx, same clock_enable, receiver ready=1, send 0x00, 0xFF, 0x3C -> receiver pulses valid with data 0x00, 0xFF, 0x3C in order.
REQ-033 SHALL cover this scenario: valid held high with 0x55 then 0x81 -> second start bit begins on the edge after ready rises; no idle ticks between stop and start.
REQ-034 SHALL cover this scenario: clock_enable high 1 cycle in 4, send 0x01 -> every bit lasts 64 CLKIN cycles; tx changes only after enabled edges.
REQ-035 SHALL cover this scenario: RESETN pulsed low during bit 3 of 0xF0 -> tx=1 within the reset assertion, ready=0 during reset and 1 one edge after release, and no further low bits.
REQ-036 SHALL cover this scenario: valid=1 with data=0x77 asserted mid-frame of 0x12 -> 0x12 is transmitted intact, and 0x77 is accepted only once ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default oversample rate, shared by the UART transmitter and receiver
package uart_pkg;
  localparam int UART_TICKS_PER_BIT = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;
endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: LSB-first 8-bit serial transmitter, timed by an oversample clock enable
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = UART_TICKS_PER_BIT,
  parameter int STOP_BITS     = 1
) (
  input  logic       CLKIN,
  input  logic       RESETN,
  input  logic       clock_enable,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(TICKS_PER_BIT * STOP_BITS);
  localparam logic [CW-1:0] BIT_END  = CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END = CW'(TICKS_PER_BIT * STOP_BITS - 1);
  uart_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic tx_n, ready_n;
  always_ff @(posedge CLKIN or negedge RESETN)
    if (!RESETN) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx    <= 1'b1;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx    <= tx_n;
      ready <= ready_n;
    end
  // acceptance ignores clock_enable; every later step waits for an enabled tick
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    sh_n    = sh;
    tx_n    = tx;
    ready_n = 1'b0;
    if (state == IDLE) begin
      tx_n    = 1'b1;
      ready_n = !(valid && ready);
      if (valid && ready) begin
        state_n = START;
        tx_n    = 1'b0;
        cnt_n   = '0;
        idx_n   = '0;
        sh_n    = data;
      end
    end else if (clock_enable) begin
      cnt_n = cnt + 1'b1;
      case (state)
        START:
          if (cnt == BIT_END) begin
            state_n = DATA;
            cnt_n   = '0;
            tx_n    = sh[0];
          end
        DATA:
          if (cnt == BIT_END) begin
            cnt_n   = '0;
            sh_n    = sh >> 1;
            state_n = (idx == 3'd7) ? STOP : DATA;
            idx_n   = (idx == 3'd7) ? idx : idx + 3'd1;
            tx_n    = (idx == 3'd7) ? 1'b1 : sh[1];
          end
        STOP:
          if (cnt == STOP_END) begin
            state_n = IDLE;
            cnt_n   = '0;
            ready_n = 1'b1;
          end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: random frames against a serial-line model and a byte scoreboard
module tb_uart_transmitter;
  localparam int T = 16;
  localparam int S = 1;
  localparam int FRAME = (9 + S) * T;
  logic CLKIN = 1'b0;
  logic RESETN, clock_enable, valid, ready, tx;
  logic [7:0] data;
  int total = 0, bad = 0;
  int ce_mode = 1, cyc = 0;
  logic [7:0] exp_q[$];
  logic m_busy = 1'b0, m_ready = 1'b0, m_tx = 1'b1, m_pending = 1'b0;
  logic [7:0] m_byte = '0;
  int m_k = 0, acc_n = 0;
  logic dec_on = 1'b0;
  int dt = 0, j = 0;
  logic [7:0] dbyte = '0, e = '0;

  uart_transmitter #(.TICKS_PER_BIT(T), .STOP_BITS(S)) dut (
    .CLKIN(CLKIN), .RESETN(RESETN), .clock_enable(clock_enable),
    .data(data), .valid(valid), .ready(ready), .tx(tx)
  );

  always #5 CLKIN = ~CLKIN;

  function automatic logic level(input logic [7:0] b, input int k);
    if (k < T) return 1'b0;
    if (k < 9 * T) return b[(k - T) / T];
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // serial-line model: each enabled tick after acceptance advances one position in the frame
  initial forever begin
    @(posedge CLKIN or negedge RESETN);
    if (!RESETN) begin
      if (m_pending) void'(exp_q.pop_back());
      m_pending = 1'b0;
      m_busy = 1'b0;
      m_ready = 1'b0;
      m_tx = 1'b1;
    end else if (m_busy) begin
      if (clock_enable) m_k++;
      if (m_k >= FRAME) begin
        m_busy = 1'b0;
        m_ready = 1'b1;
        m_tx = 1'b1;
      end else m_tx = level(m_byte, m_k);
    end else if (m_ready && valid) begin
      m_busy = 1'b1;
      m_ready = 1'b0;
      m_k = 0;
      m_byte = data;
      m_tx = 1'b0;
      exp_q.push_back(data);
      m_pending = 1'b1;
      acc_n++;
    end else begin
      m_ready = 1'b1;
      m_tx = 1'b1;
    end
  end

  // line checker plus receiver-style decoder feeding the byte scoreboard
  initial forever begin
    @(negedge CLKIN);
    chk("tx_line", tx, m_tx);
    chk("ready", ready, m_ready);
    if (!RESETN) dec_on = 1'b0;
    else if (!dec_on) begin
      if (tx === 1'b0) begin
        dec_on = 1'b1;
        dt = 0;
      end
    end else if (clock_enable) begin
      dt++;
      if (dt % T == T / 2) begin
        j = dt / T;
        if (j == 0) chk("start_bit", tx, 0);
        else if (j < 9) dbyte[j-1] = tx;
        else begin
          chk("stop_bit", tx, 1);
          dec_on = 1'b0;
          m_pending = 1'b0;
          if (exp_q.size() == 0) chk("unexpected_byte", dbyte, 32'hFFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("rx_byte", dbyte, e);
          end
        end
      end
    end
  end

  initial begin
    clock_enable = 1'b1;
    forever begin
      @(posedge CLKIN);
      #1;
      cyc++;
      clock_enable = (ce_mode == 0) ? 1'($urandom % 2) : (cyc % ce_mode == 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLKIN);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    int n0, c;
    n0 = acc_n;
    c = 0;
    valid = 1'b1;
    data = b;
    while (acc_n == n0 && c < 3000) begin
      tick(1);
      c++;
    end
    total++;
    if (acc_n == n0) begin
      bad++;
      $display("FAIL accept_timeout: byte %h not accepted in %0d cycles, required within 3000", b, c);
    end
    valid = keep;
    data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((m_busy || exp_q.size() != 0 || !m_ready) && c < 5000) begin
      tick(1);
      c++;
    end
    total++;
    if (c >= 5000) begin
      bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle within 5000", c);
    end
  endtask

  initial begin
    int c;
    RESETN = 1'b1;
    valid = 1'b0;
    data = '0;
    #1 RESETN = 1'b0;
    tick(3);
    RESETN = 1'b1;
    send(8'hA5, 1'b0);
    c = 0;
    while (ready !== 1'b1 && c < 400) begin
      tick(1);
      c++;
    end
    chk("a5_frame_cycles", c, 160);
    wait_idle();
    foreach (exp_q[i]) chk("queue_drained", 1, 0);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h3C, 1'b0);
    wait_idle();
    send(8'h55, 1'b1);
    send(8'h81, 1'b0);
    wait_idle();
    ce_mode = 4;
    send(8'h01, 1'b0);
    wait_idle();
    ce_mode = 1;
    tick(2);
    send(8'hF0, 1'b0);
    tick(4 * T + T / 2);
    RESETN = 1'b0;
    tick(2);
    RESETN = 1'b1;
    tick(FRAME + 20);
    send(8'h12, 1'b0);
    tick(3 * T);
    valid = 1'b1;
    data = 8'h77;
    tick(T);
    send(8'h77, 1'b0);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      ce_mode = int'($urandom % 4);
      send(8'($urandom), 1'($urandom % 2));
      if (!valid) tick(int'($urandom % 5));
    end
    valid = 1'b0;
    wait_idle();
    ce_mode = 1;
    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
